// File: rtl/instr_prefetch_pkg.sv
// Shared fetch types and constants for the instruction prefetch front end.
package instr_prefetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry circular buffer of {pc, instr}; head visible the cycle after push.
// Push into a full buffer is ignored unless a pop frees the slot; flush beats push.
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resn,
  input  logic                         push,
  input  logic [31:0]                  push_pc,
  input  logic [31:0]                  push_instr,
  input  logic                         pop,
  input  logic                         flush,
  output logic [31:0]                  head_pc,
  output logic [31:0]                  head_instr,
  output logic                         not_empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign not_empty  = (occ != '0);
  assign do_pop     = pop && not_empty;
  assign do_push    = push && ((occ != CW'(DEPTH)) || do_pop);
  assign head_pc    = mem[rptr].pc;
  assign head_instr = mem[rptr].instr;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= '{pc: push_pc, instr: push_instr};
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      occ <= occ + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Fetch front end: issues word fetches, buffers responses, redirect flushes and drops stale data.
// r_valid -> fetch_valid one cycle later (same cycle with INSTR_PREFETCH_BYPASS_EN); requests stop when buffer+in-flight reach DEPTH.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resn,
  output logic        instr_req,
  input  logic        instr_gnt,
  output logic [31:0] instr_adr,
  input  logic        instr_r_valid,
  input  logic [31:0] instr_read_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc
);

  localparam int             CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0]    LIMIT = (CW + 1)'(DEPTH);
  localparam logic [31:0]    STEP  = 32'(INSTR_BYTES);

  logic          run;
  logic          hold;
  logic          redir_pend;
  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [31:0]   redir_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occ;
  logic [31:0]   new_pc;
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;
  logic          fifo_vld;
  logic          grant;
  logic          rsp;
  logic          keep;
  logic          byp;
  logic          push;
  logic          pop;

  assign new_pc    = redirect_pc & ~32'h3;
  assign instr_req = run && (hold || (({1'b0, occ} + {1'b0, out_cnt}) < LIMIT));
  assign instr_adr = fpc;
  assign grant     = instr_req && instr_gnt;
  assign rsp       = instr_r_valid && (out_cnt != '0);
  assign keep      = rsp && (drop_cnt == '0) && !redirect;

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign byp = keep && (occ == '0);
`else
  assign byp = 1'b0;
`endif

  assign fetch_valid = fifo_vld || byp;
  assign fetch_pc    = byp ? rpc : head_pc;
  assign fetch_instr = byp ? instr_read_in : head_instr;
  assign push        = keep && !(byp && fetch_ready);
  assign pop         = fifo_vld && fetch_ready && !redirect;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      run        <= 1'b0;
      hold       <= 1'b0;
      redir_pend <= 1'b0;
      fpc        <= RESET_PC;
      rpc        <= RESET_PC;
      redir_pc   <= RESET_PC;
      out_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      run      <= 1'b1;
      hold     <= instr_req && !instr_gnt;
      out_cnt  <= out_cnt + CW'(grant) - CW'(rsp);
      drop_cnt <= drop_cnt - CW'(rsp && (drop_cnt != '0)) + CW'(grant && redir_pend);
      if (keep) rpc <= rpc + STEP;
      if (grant) begin
        // A held request granted after a redirect resumes fetch at the redirect target.
        if (redir_pend) begin
          fpc        <= redir_pc;
          redir_pend <= 1'b0;
        end else begin
          fpc <= fpc + STEP;
        end
      end
      if (redirect) begin
        rpc      <= new_pc;
        drop_cnt <= out_cnt + CW'(grant) - CW'(rsp);
        if (hold && !instr_gnt) begin
          redir_pend <= 1'b1;
          redir_pc   <= new_pc;
        end else begin
          fpc        <= new_pc;
          redir_pend <= 1'b0;
        end
      end
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resn      (resn),
    .push      (push),
    .push_pc   (rpc),
    .push_instr(instr_read_in),
    .pop       (pop),
    .flush     (redirect),
    .head_pc   (head_pc),
    .head_instr(head_instr),
    .not_empty (fifo_vld),
    .occ       (occ)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: in-order memory responder, queue-based reference model, directed scenarios.
`timescale 1ns/1ps
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resn = 1'b0;
  logic        instr_req;
  logic        instr_gnt = 1'b0;
  logic [31:0] instr_adr;
  logic        instr_r_valid = 1'b0;
  logic [31:0] instr_read_in = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit gnt_en = 0;
  bit resp_en = 0;
  bit model_on = 0;

  // memory side: granted addresses awaiting response, with grant cycle
  logic [31:0] pend_q[$];
  int          pend_cyc[$];

  // reference model state
  fetch_entry_t mq[$];
  fetch_entry_t ent;
  logic [31:0]  fpc_m, rpc_m, pend_pc_m, tgt;
  int           drop_m;
  bit           held_m, pend_redir_m, run_m;
  bit           exp_req, exp_vld, rv, keep, byp, g;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .resn         (resn),
    .instr_req    (instr_req),
    .instr_gnt    (instr_gnt),
    .instr_adr    (instr_adr),
    .instr_r_valid(instr_r_valid),
    .instr_read_in(instr_read_in),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_instr  (fetch_instr),
    .fetch_pc     (fetch_pc)
  );

  always #5 clk = ~clk;

  // word at address a is "addi x(n&31), x0, n" with n = a/4
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] n;
    n = a[13:2];
    return 32'h13 | ({20'h0, n} << 20) | ({27'h0, n[4:0]} << 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory responder: one response per cycle, at least one cycle after grant
  always @(posedge clk) begin
    cyc++;
    #1;
    instr_gnt = gnt_en;
    if (resp_en && pend_q.size() != 0 && pend_cyc[0] < cyc) begin
      instr_r_valid = 1'b1;
      instr_read_in = mem_word(pend_q[0]);
    end else begin
      instr_r_valid = 1'b0;
      instr_read_in = 32'hDEAD_BEEF;
    end
  end

  // reference model and per-cycle compare
  always @(negedge clk) begin
    if (model_on) begin
      exp_req = run_m && (held_m || (mq.size() + pend_q.size() < DEPTH));
      check("req", instr_req, exp_req);
      if (exp_req) check("adr", instr_adr, fpc_m);
      rv   = instr_r_valid;
      keep = rv && drop_m == 0 && !redirect;
      byp  = 0;
`ifdef INSTR_PREFETCH_BYPASS_EN
      byp  = keep && mq.size() == 0;
`endif
      exp_vld = (mq.size() != 0) || byp;
      check("fetch_valid", fetch_valid, exp_vld);
      if (mq.size() != 0) begin
        check("fetch_pc", fetch_pc, mq[0].pc);
        check("fetch_instr", fetch_instr, mq[0].instr);
      end else if (byp) begin
        check("byp_pc", fetch_pc, rpc_m);
        check("byp_instr", fetch_instr, mem_word(rpc_m));
      end
      g = exp_req && instr_gnt;
      if (rv) begin
        void'(pend_q.pop_front());
        void'(pend_cyc.pop_front());
        if (drop_m > 0) drop_m--;
      end
      if (exp_vld && fetch_ready && !redirect && mq.size() != 0) void'(mq.pop_front());
      if (keep) begin
        ent.pc = rpc_m;
        ent.instr = mem_word(rpc_m);
        if (!(byp && fetch_ready)) mq.push_back(ent);
        rpc_m += 4;
      end
      if (g) begin
        pend_q.push_back(fpc_m);
        pend_cyc.push_back(cyc);
        if (held_m && pend_redir_m) begin
          drop_m++;
          fpc_m = pend_pc_m;
          pend_redir_m = 0;
        end else begin
          fpc_m += 4;
        end
      end
      if (redirect) begin
        tgt = {redirect_pc[31:2], 2'b00};
        mq.delete();
        rpc_m  = tgt;
        drop_m = pend_q.size();
        if (held_m && !g) begin
          pend_redir_m = 1;
          pend_pc_m = tgt;
        end else begin
          fpc_m = tgt;
          pend_redir_m = 0;
        end
      end
      held_m = exp_req && !g;
      run_m  = 1;
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic expect_pop(input string name, input logic [31:0] pc, input logic [31:0] ins);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fetch_valid && fetch_ready) && n < 30);
    check({name, "_vld"}, {31'h0, fetch_valid && fetch_ready}, 32'h1);
    check({name, "_pc"}, fetch_pc, pc);
    check({name, "_instr"}, fetch_instr, ins);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'h0, instr_req}, 32'h0);
    check("rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_adr", instr_adr, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_fetch_instr", fetch_instr, 32'h0);

    @(posedge clk); #1;
    fpc_m = 32'h0; rpc_m = 32'h0; drop_m = 0;
    held_m = 0; pend_redir_m = 0; run_m = 0;
    model_on = 1;
    resn = 1'b1;
    @(negedge clk);
    check("release_req", {31'h0, instr_req}, 32'h0);
    @(negedge clk);
    check("first_req", {31'h0, instr_req}, 32'h1);
    check("first_adr", instr_adr, 32'h0);

    // stream
    gnt_en = 1; resp_en = 1; fetch_ready = 1'b1;
    expect_pop("stream0", 32'h0, 32'h0000_0013);
    expect_pop("stream1", 32'h4, 32'h0010_0093);
    expect_pop("stream2", 32'h8, 32'h0020_0113);
    repeat (6) @(negedge clk);

    // backpressure
    fetch_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_req", {31'h0, instr_req}, 32'h0);
    check("bp_valid", {31'h0, fetch_valid}, 32'h1);
    @(posedge clk); #1 fetch_ready = 1'b1;
    @(posedge clk); #1 fetch_ready = 1'b0;
    @(negedge clk);
    check("bp_resume_req", {31'h0, instr_req}, 32'h1);
    repeat (4) @(negedge clk);

    // stalled grant after redirect from a full buffer
    gnt_en = 0; resp_en = 0;
    do_redirect(32'h8);
    @(negedge clk);
    check("stall0_req", {31'h0, instr_req}, 32'h1);
    check("stall0_adr", instr_adr, 32'h8);
    repeat (2) @(negedge clk);
    check("stall3_req", {31'h0, instr_req}, 32'h1);
    check("stall3_adr", instr_adr, 32'h8);
    gnt_en = 1;
    repeat (3) @(negedge clk);
    check("two_out_req", {31'h0, instr_req}, 32'h0);

    // redirect with two responses outstanding
    do_redirect(32'h102);
    resp_en = 1; fetch_ready = 1'b1;
    expect_pop("redir100", 32'h100, 32'h0400_0013);
    expect_pop("redir104", 32'h104, 32'h0410_0093);

    // redirect while a request is held without grant
    fetch_ready = 1'b0;
    repeat (8) @(negedge clk);
    gnt_en = 0;
    do_redirect(32'h10);
    do_redirect(32'h200);
    @(negedge clk);
    check("held_req", {31'h0, instr_req}, 32'h1);
    check("held_adr", instr_adr, 32'h10);
    gnt_en = 1;
    @(negedge clk);
    @(negedge clk);
    check("after_hold_adr", instr_adr, 32'h200);
    fetch_ready = 1'b1;
    expect_pop("redir200", 32'h200, 32'h0800_0013);
`ifdef INSTR_PREFETCH_BYPASS_EN
    check("byp_same_cycle", {31'h0, instr_r_valid}, 32'h1);
`endif
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, tests=%0d failures=%0d", tests, fails);
    $fatal(1);
  end

endmodule
